// File: rtl/circle_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : circle_pkg
//  Description : Shared types for the midpoint circle plotter: FSM state
//                encoding, the octant sign/swap table and the guard widths
//                used to size the signed coordinate and decision datapaths.
//  Revision    : 1.0  initial release
// ============================================================================
package circle_pkg;

   // Guard bits added to the coordinate width so cx+/-ox never wraps
   localparam int COORD_GUARD = 2;
   // Guard bits added to X_W for the midpoint decision variable
   localparam int CRIT_GUARD  = 3;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      INIT = 3'd1,
      OCT  = 3'd2,
      SPAN = 3'd3,
      STEP = 3'd4,
      DONE = 3'd5
   } state_t;

   // One octant: negate x offset, negate y offset, swap ox/oy roles
   typedef struct packed {
      logic neg_x;
      logic neg_y;
      logic swap;
   } oct_entry_t;

   // Octant order: (+ox,+oy) (+oy,+ox) (-ox,+oy) (-oy,+ox)
   //               (-ox,-oy) (-oy,-ox) (+ox,-oy) (+oy,-ox)
   function automatic oct_entry_t oct_entry(input logic [2:0] oct);
      oct_entry_t e;
      case (oct)
         3'd0:    e = '{neg_x: 1'b0, neg_y: 1'b0, swap: 1'b0};
         3'd1:    e = '{neg_x: 1'b0, neg_y: 1'b0, swap: 1'b1};
         3'd2:    e = '{neg_x: 1'b1, neg_y: 1'b0, swap: 1'b0};
         3'd3:    e = '{neg_x: 1'b1, neg_y: 1'b0, swap: 1'b1};
         3'd4:    e = '{neg_x: 1'b1, neg_y: 1'b1, swap: 1'b0};
         3'd5:    e = '{neg_x: 1'b1, neg_y: 1'b1, swap: 1'b1};
         3'd6:    e = '{neg_x: 1'b0, neg_y: 1'b1, swap: 1'b0};
         default: e = '{neg_x: 1'b0, neg_y: 1'b1, swap: 1'b1};
      endcase
      return e;
   endfunction

endpackage
`default_nettype wire

// File: rtl/circle_plotter_pixel_clip.sv
`default_nettype none
// ============================================================================
//  Module      : pixel_clip
//  Description : Combinational screen clipper. Takes a signed candidate pixel
//                and returns the unsigned screen coordinate plus a valid bit;
//                off-screen pixels yield valid=0 and x=y=0.
//  Revision    : 1.0  initial release
// ============================================================================
module pixel_clip #(
   parameter int SCREEN_W = 160,
   parameter int SCREEN_H = 120,
   parameter int X_W      = 8,
   parameter int Y_W      = 7,
   parameter int CW       = 10
) (
   input  logic signed [CW-1:0] px,
   input  logic signed [CW-1:0] py,
   output logic [X_W-1:0]       x,
   output logic [Y_W-1:0]       y,
   output logic                 valid
);

   localparam logic signed [CW-1:0] SW_S = CW'(SCREEN_W);
   localparam logic signed [CW-1:0] SH_S = CW'(SCREEN_H);

   // Bounds test and zeroing of rejected pixels
   always_comb begin
      valid = !px[CW-1] && (px < SW_S) && !py[CW-1] && (py < SH_S);
      x     = '0;
      y     = '0;
      if (valid) begin
         x = px[X_W-1:0];
         y = py[Y_W-1:0];
      end
   end

endmodule
`default_nettype wire

// File: rtl/circle_plotter.sv
`default_nettype none
// ============================================================================
//  Module      : circle_plotter
//  Description : Midpoint (Bresenham) circle plotter feeding a VGA adapter,
//                one candidate pixel per clock with per-pixel clipping.
//                Optional filled-disc mode via CIRCLE_PLOTTER_FILL_EN: when
//                defined and fill is latched high, each pass emits four
//                horizontal spans instead of eight octant points.
//  Revision    : 1.0  initial release
// ============================================================================
module circle_plotter
   import circle_pkg::*;
#(
   parameter int SCREEN_W = 160,
   parameter int SCREEN_H = 120,
   parameter int X_W      = 8,
   parameter int Y_W      = 7,
   parameter int COLOUR_W = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [X_W-1:0]      centre_x,
   input  logic [Y_W-1:0]      centre_y,
   input  logic [X_W-1:0]      radius,
   input  logic [COLOUR_W-1:0] colour,
   input  logic                fill,
   output logic                done,
   output logic [X_W-1:0]      vga_x,
   output logic [Y_W-1:0]      vga_y,
   output logic [COLOUR_W-1:0] vga_colour,
   output logic                vga_plot
);

   // Coordinates share one width wide enough for both axes so y+ox cannot wrap
   localparam int CW = ((X_W > Y_W) ? X_W : Y_W) + COORD_GUARD;
   localparam int RW = X_W + CRIT_GUARD;

   localparam logic signed [CW-1:0] ONE_C = CW'(1);
   localparam logic signed [RW-1:0] ONE_R = RW'(1);

   state_t state, state_next;

   logic signed [CW-1:0]  cx, cy, ox, oy;
   logic signed [RW-1:0]  crit;
   logic [X_W-1:0]        rad;
   logic [COLOUR_W-1:0]   col;
   logic [2:0]            oct;

   logic signed [CW-1:0]  oy_n, ox_n, rad_ext;
   logic signed [RW-1:0]  crit_n, oy_r, ox_r;
   logic                  crit_pos;

   logic signed [CW-1:0]  px, py, off_a, off_b;
   logic                  want;
   oct_entry_t            ent;

   logic [X_W-1:0]        clip_x;
   logic [Y_W-1:0]        clip_y;
   logic                  clip_ok;

`ifdef CIRCLE_PLOTTER_FILL_EN
   logic                  fill_q;
   logic [1:0]            sp;
   logic signed [CW-1:0]  span_off, span_h;
   logic                  span_last;

   assign span_h    = sp[1] ? oy : ox;
   assign span_last = (sp == 2'd3) && (span_off == span_h);
`else
   logic                  unused_fill;
   assign unused_fill = fill;
`endif

   assign rad_ext = $signed({{(CW-X_W){1'b0}}, rad});

   // Midpoint step: advance oy, conditionally retreat ox, update decision
   always_comb begin
      crit_pos = !crit[RW-1] && (crit != '0);
      oy_n     = oy + ONE_C;
      ox_n     = crit_pos ? (ox - ONE_C) : ox;
      oy_r     = RW'(oy_n);
      ox_r     = RW'(ox_n);
      crit_n   = crit_pos ? (crit + ((oy_r - ox_r) <<< 1) + ONE_R)
                          : (crit + (oy_r <<< 1) + ONE_R);
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (start) state_next = INIT;
`ifdef CIRCLE_PLOTTER_FILL_EN
         INIT: state_next = fill_q ? SPAN : OCT;
         SPAN: if (span_last) state_next = STEP;
         STEP: state_next = (oy_n <= ox_n) ? (fill_q ? SPAN : OCT) : DONE;
`else
         INIT: state_next = OCT;
         STEP: state_next = (oy_n <= ox_n) ? OCT : DONE;
`endif
         OCT:  if (oct == 3'd7) state_next = STEP;
         DONE: if (!start) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Candidate pixel for the current cycle
   always_comb begin
      px    = '0;
      py    = '0;
      want  = 1'b0;
      ent   = oct_entry(oct);
      off_a = ox;
      off_b = oy;
      case (state)
         OCT: begin
            want = 1'b1;
            if (ent.swap) begin
               off_a = oy;
               off_b = ox;
            end
            px = ent.neg_x ? (cx - off_a) : (cx + off_a);
            py = ent.neg_y ? (cy - off_b) : (cy + off_b);
         end
`ifdef CIRCLE_PLOTTER_FILL_EN
         SPAN: begin
            want = 1'b1;
            px   = cx + span_off;
            case (sp)
               2'd0:    py = cy + oy;
               2'd1:    py = cy - oy;
               2'd2:    py = cy + ox;
               default: py = cy - ox;
            endcase
         end
`endif
         default: ;
      endcase
   end

   pixel_clip #(
      .SCREEN_W (SCREEN_W),
      .SCREEN_H (SCREEN_H),
      .X_W      (X_W),
      .Y_W      (Y_W),
      .CW       (CW)
   ) u_clip (
      .px    (px),
      .py    (py),
      .x     (clip_x),
      .y     (clip_y),
      .valid (clip_ok)
   );

   // Draw datapath: input latch, midpoint registers and pixel walk counters
   always_ff @(posedge clk) begin
      if (rst) begin
         cx   <= '0;
         cy   <= '0;
         rad  <= '0;
         col  <= '0;
         ox   <= '0;
         oy   <= '0;
         crit <= '0;
         oct  <= '0;
`ifdef CIRCLE_PLOTTER_FILL_EN
         fill_q   <= 1'b0;
         sp       <= '0;
         span_off <= '0;
`endif
      end else begin
         case (state)
            IDLE: if (start) begin
               cx  <= $signed({{(CW-X_W){1'b0}}, centre_x});
               cy  <= $signed({{(CW-Y_W){1'b0}}, centre_y});
               rad <= radius;
               col <= colour;
`ifdef CIRCLE_PLOTTER_FILL_EN
               fill_q <= fill;
`endif
            end
            INIT: begin
               ox   <= rad_ext;
               oy   <= '0;
               crit <= ONE_R - $signed({{(RW-X_W){1'b0}}, rad});
               oct  <= '0;
`ifdef CIRCLE_PLOTTER_FILL_EN
               sp       <= '0;
               span_off <= -rad_ext;
`endif
            end
            OCT: oct <= oct + 3'd1;
`ifdef CIRCLE_PLOTTER_FILL_EN
            SPAN: begin
               if (span_off == span_h) begin
                  sp       <= sp + 2'd1;
                  // Spans 0..1 walk +/-ox, spans 2..3 walk +/-oy
                  span_off <= (sp == 2'd0) ? -ox : -oy;
               end else begin
                  span_off <= span_off + ONE_C;
               end
            end
`endif
            STEP: begin
               oy   <= oy_n;
               ox   <= ox_n;
               crit <= crit_n;
               oct  <= '0;
`ifdef CIRCLE_PLOTTER_FILL_EN
               sp       <= '0;
               span_off <= -ox_n;
`endif
            end
            default: ;
         endcase
      end
   end

   // Registered VGA outputs and completion flag
   always_ff @(posedge clk) begin
      if (rst) begin
         done       <= 1'b0;
         vga_plot   <= 1'b0;
         vga_x      <= '0;
         vga_y      <= '0;
         vga_colour <= '0;
      end else begin
         done       <= (state_next == DONE);
         vga_plot   <= want && clip_ok;
         vga_x      <= clip_x;
         vga_y      <= clip_y;
         vga_colour <= want ? col : '0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_circle_plotter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_circle_plotter
//  Description : Directed bench for circle_plotter. Draw tasks push the
//                hand-derived pixel sequence into a queue; a monitor pops and
//                compares on every vga_plot strobe.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_circle_plotter;

   typedef struct packed {
      logic [7:0] x;
      logic [6:0] y;
      logic [2:0] c;
   } pix_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] centre_x;
   logic [6:0] centre_y;
   logic [7:0] radius;
   logic [2:0] colour;
   logic       fill;
   logic       done;
   logic [7:0] vga_x;
   logic [6:0] vga_y;
   logic [2:0] vga_colour;
   logic       vga_plot;

   pix_t exp_q[$];
   pix_t sb_e;
   int   errors   = 0;
   int   checks   = 0;
   int   plot_cnt = 0;
   bit   sb_en    = 1'b1;

   circle_plotter #(
      .SCREEN_W (160),
      .SCREEN_H (120),
      .X_W      (8),
      .Y_W      (7),
      .COLOUR_W (3)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .centre_x   (centre_x),
      .centre_y   (centre_y),
      .radius     (radius),
      .colour     (colour),
      .fill       (fill),
      .done       (done),
      .vga_x      (vga_x),
      .vga_y      (vga_y),
      .vga_colour (vga_colour),
      .vga_plot   (vga_plot)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic push(input int x, input int y, input int c);
      pix_t p;
      p.x = x[7:0];
      p.y = y[6:0];
      p.c = c[2:0];
      exp_q.push_back(p);
   endtask

   // Scoreboard monitor: every plot strobe is popped and compared
   always @(negedge clk) begin
      if (!rst && vga_plot === 1'b1) begin
         plot_cnt++;
         if (sb_en) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_plot: got (%0d,%0d) c=%0d, expected no plot",
                        vga_x, vga_y, vga_colour);
            end else begin
               sb_e = exp_q.pop_front();
               if ({vga_x, vga_y, vga_colour} !== sb_e) begin
                  errors++;
                  $display("FAIL pixel: got (%0d,%0d) c=%0d, expected (%0d,%0d) c=%0d",
                           vga_x, vga_y, vga_colour, sb_e.x, sb_e.y, sb_e.c);
               end
            end
         end
      end
   end

   // One draw: start sampled at the first posedge, latency counted to done
   task automatic draw(input string name, input int cx, input int cy, input int r,
                       input int col, input bit f, input int exp_lat,
                       input int exp_plots, input bit hold);
      int cnt;
      int p0;
      @(negedge clk);
      centre_x = cx[7:0];
      centre_y = cy[6:0];
      radius   = r[7:0];
      colour   = col[2:0];
      fill     = f;
      start    = 1'b1;
      p0       = plot_cnt;
      @(posedge clk);
      cnt = 0;
      do begin
         @(posedge clk);
         #1;
         cnt++;
      end while (!done && cnt < 3000);
      check({name, "_latency"}, cnt, exp_lat);
      check({name, "_plot_count"}, plot_cnt - p0, exp_plots);
      if (sb_en) check({name, "_queue_left"}, exp_q.size(), 0);
      // Scramble inputs: they must be ignored after the latch
      centre_x = 8'd3;
      radius   = 8'd77;
      if (!hold) begin
         @(negedge clk);
         start = 1'b0;
         @(posedge clk);
         #1;
         check({name, "_done_release"}, int'(done), 0);
      end
   endtask

   int r1x[16] = '{81, 80, 79, 80, 79, 80, 81, 80, 81, 81, 79, 79, 79, 79, 81, 81};
   int r1y[16] = '{60, 61, 60, 61, 60, 59, 60, 59, 61, 61, 61, 61, 59, 59, 59, 59};
   int r5x[10] = '{5, 0, 0, 5, 5, 1, 5, 2, 4, 3};
   int r5y[10] = '{0, 5, 5, 0, 1, 5, 2, 5, 3, 4};
`ifdef CIRCLE_PLOTTER_FILL_EN
   int fx[20] = '{9, 10, 11, 9, 10, 11, 10, 10, 9, 10, 11, 9, 10, 11, 9, 10, 11, 9, 10, 11};
   int fy[20] = '{10, 10, 10, 10, 10, 10, 11, 9, 11, 11, 11, 9, 9, 9, 11, 11, 11, 9, 9, 9};
`endif

   initial begin
      int p0;
      rst      = 1'b1;
      start    = 1'b0;
      centre_x = '0;
      centre_y = '0;
      radius   = '0;
      colour   = '0;
      fill     = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_done", int'(done), 0);
      check("reset_plot", int'(vga_plot), 0);
      check("reset_x", int'(vga_x), 0);
      check("reset_y", int'(vga_y), 0);
      check("reset_colour", int'(vga_colour), 0);
      rst = 1'b0;

      // Radius 0: eight plots at the centre
      for (int i = 0; i < 8; i++) push(80, 60, 6);
      draw("r0_centre", 80, 60, 0, 6, 1'b0, 10, 8, 1'b0);

      // Radius 1: two passes, 16 plots
      for (int i = 0; i < 16; i++) push(r1x[i], r1y[i], 4);
      draw("r1_centre", 80, 60, 1, 4, 1'b0, 19, 16, 1'b0);

      // Radius 5 at the origin: only the non-negative quadrant survives clipping
      for (int i = 0; i < 10; i++) push(r5x[i], r5y[i], 3);
      draw("r5_origin", 0, 0, 5, 3, 1'b0, 37, 10, 1'b0);

      // Radius 5 fully on-screen: same timing, all 32 plots land
      sb_en = 1'b0;
      draw("r5_middle", 80, 60, 5, 1, 1'b0, 37, 32, 1'b0);

      // Reset during the third pass of radius 20
      @(negedge clk);
      centre_x = 8'd80;
      centre_y = 7'd60;
      radius   = 8'd20;
      colour   = 3'd2;
      start    = 1'b1;
      @(posedge clk);
      repeat (22) @(posedge clk);
      @(negedge clk);
      rst   = 1'b1;
      start = 1'b0;
      @(posedge clk);
      #1;
      check("abort_plot", int'(vga_plot), 0);
      check("abort_done", int'(done), 0);
      @(negedge clk);
      rst = 1'b0;
      p0  = plot_cnt;
      repeat (12) @(negedge clk);
      check("abort_no_plots", plot_cnt - p0, 0);
      check("abort_idle_done", int'(done), 0);
      sb_en = 1'b1;
      for (int i = 0; i < 8; i++) push(10, 20, 5);
      draw("after_abort", 10, 20, 0, 5, 1'b0, 10, 8, 1'b0);

      // start held through DONE: no retrigger
      for (int i = 0; i < 16; i++) push(r1x[i], r1y[i], 2);
      draw("held", 80, 60, 1, 2, 1'b0, 19, 16, 1'b1);
      p0 = plot_cnt;
      repeat (20) @(negedge clk);
      check("held_done", int'(done), 1);
      check("held_no_replot", plot_cnt - p0, 0);
      start = 1'b0;
      @(posedge clk);
      #1;
      check("held_release", int'(done), 0);
      for (int i = 0; i < 8; i++) push(30, 40, 7);
      draw("relatch", 30, 40, 0, 7, 1'b0, 10, 8, 1'b0);

`ifdef CIRCLE_PLOTTER_FILL_EN
      // Filled radius 1: 3x3 block, passes of 8 and 12 pixels
      for (int i = 0; i < 20; i++) push(fx[i], fy[i], 1);
      draw("fill_r1", 10, 10, 1, 1, 1'b1, 23, 20, 1'b0);
`else
      // fill is ignored when the feature is compiled out
      for (int i = 0; i < 8; i++) push(10, 10, 1);
      draw("fill_ignored", 10, 10, 0, 1, 1'b1, 10, 8, 1'b0);
`endif

      repeat (4) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
